poly_feeder: RTL

Upstream feeder for the cubic-polynomial compute stage. Holds a double-buffered bank of four 12-bit signed coefficients, buffers incoming x samples in a small FIFO, and issues one sample per cycle to the compute stage. It also delays a valid bit by the compute latency, so the compute result is tagged valid on the way out. Coefficient changes wait until the compute pipeline has drained, so no in-flight sample ever sees a mix of old and new coefficients.

---
 rtl/poly_feeder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/poly_feeder.sv
// Feeder for the cubic-polynomial compute stage: double-buffered coefficient bank,
// sample FIFO, one-per-cycle issue and a valid-delay line matching the compute latency.
module poly_feeder #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  output logic [11:0] x,
  output logic        x_valid,
  output logic [11:0] param_out0,
  output logic [11:0] param_out1,
  output logic [11:0] param_out2,
  output logic [11:0] param_out3,
  input  logic [11:0] out_in,
  output logic        m_valid,
  output logic [11:0] m_data,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state;
  state_t state_next;

  logic [11:0]        shadow [4];
  logic [11:0]        shadow_eff [4];
  logic [3:0]         written_mask;
  logic [3:0]         write_bit;
  logic [3:0]         mask_eff;
  logic               cfg_write;
  logic               commit_req;
  logic               commit_ok;
  logic               drained;
  logic               issue;
  logic               swap;

  logic [11:0]        fifo_mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               empty;
  logic               push;

  logic [LATENCY-1:0] vpipe;

  // A write in the same cycle as a commit lands first, so it counts toward the mask
  assign cfg_ready  = (state != DRAIN);
  assign cfg_write  = cfg_valid && cfg_ready;
  assign write_bit  = cfg_write ? (4'b0001 << cfg_addr) : 4'b0000;
  assign mask_eff   = written_mask | write_bit;
  assign commit_req = cfg_commit && (state != DRAIN);
  assign commit_ok  = commit_req && (mask_eff == 4'hF);
  assign drained    = !x_valid && (vpipe == '0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shadow_eff[i] = write_bit[i] ? cfg_data : shadow[i];
    end
  end

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign s_ready = !full;
  assign push    = s_valid && s_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit_ok) state_next = RUN;
      RUN:     if (commit_ok) state_next = DRAIN;
      DRAIN:   if (drained)   state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Issue is suppressed in the cycle a commit is accepted from RUN
  always_comb begin
    issue = 1'b0;
    swap  = 1'b0;
    case (state)
      IDLE:    swap  = commit_ok;
      RUN:     issue = !empty && !commit_ok;
      DRAIN:   swap  = drained;
      default: begin
        issue = 1'b0;
        swap  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      written_mask <= 4'h0;
      for (int i = 0; i < 4; i++) shadow[i] <= 12'h000;
    end else begin
      written_mask <= swap ? 4'h0 : mask_eff;
      if (cfg_write) shadow[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      param_out0 <= 12'h000;
      param_out1 <= 12'h000;
      param_out2 <= 12'h000;
      param_out3 <= 12'h000;
    end else if (swap) begin
      param_out0 <= shadow_eff[0];
      param_out1 <= shadow_eff[1];
      param_out2 <= shadow_eff[2];
      param_out3 <= shadow_eff[3];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= commit_req && (mask_eff != 4'hF);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(issue);
    end
  end

  // x keeps its last sample when nothing is issued
  always_ff @(posedge clock) begin
    if (reset) begin
      x       <= 12'h000;
      x_valid <= 1'b0;
      vpipe   <= '0;
    end else begin
      x_valid <= issue;
      if (issue) x <= fifo_mem[rd_ptr];
      vpipe <= (vpipe << 1) | LATENCY'(x_valid);
    end
  end

  assign m_valid = vpipe[LATENCY-1];
  assign m_data  = out_in;
  assign busy    = !empty || x_valid || (vpipe != '0) || (state == DRAIN);

endmodule
